ex_seq_ctrl: RTL and testbench
==============================

# ex_seq_ctrl

EX-stage sequencer between the ID issue side and the combinational EX ALU. It accepts one decoded operation per handshake. Single-cycle ALU ops pass through with one cycle of latency into a registered result slot. CMD_MUL is run as a REG_LENGTH-iteration shift-and-add loop that reuses the ALU's CMD_ADD path. Results leave through a valid/ready slot toward MEM/WB.

## Interface
- REG_LENGTH, 32, data width
- REG_ADDR_LEN, 5, register address width
- OP_LENGTH, 6, op code width
- CMD_ADD_CODE, 6'h01, op code EX decodes as add
- CMD_MUL_CODE, 6'h20, op code handled here as iterative multiply; never forwarded to the ALU

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  issue request
- in_ready  out  1  issue accepted when in_valid && in_ready at a clock edge
- in_op  in  OP_LENGTH  op code
- in_a, in_b  in  REG_LENGTH  operands
- in_wr  in  1  destination write enable
- in_addr  in  REG_ADDR_LEN  destination address
- alu_op  out  OP_LENGTH  to EX op
- alu_a, alu_b  out  REG_LENGTH  to EX regaData/regbData
- alu_result  in  REG_LENGTH  from EX regcData, same cycle
- out_valid  out  1  result slot full
- out_ready  in  1  downstream takes slot
- out_data  out  REG_LENGTH  result
- out_wr  out  1  copied in_wr
- out_addr  out  REG_ADDR_LEN  copied in_addr
- busy  out  1  state != IDLE

## Operation
- States: IDLE, MUL, WB.
- slot_free = !out_valid || out_ready.
- in_ready = rst_n && state==IDLE && slot_free. Combinational.
- ALU drive in IDLE: alu_op=in_op, alu_a=in_a, alu_b=in_b.
- ALU drive in MUL and WB: alu_op=CMD_ADD_CODE, alu_a=acc, alu_b=mcand.
- IDLE, accept of non-MUL op:
  - out_data<=alu_result, out_wr<=in_wr, out_addr<=in_addr, out_valid<=1.
  - Stay in IDLE.
  - Unknown op codes are treated the same way; whatever alu_result shows is captured.
- IDLE, accept of CMD_MUL:
  - acc<=0, mcand<=in_a, mplier<=in_b, cnt<=0.
  - Latch in_wr and in_addr.
  - Go to MUL.
- MUL, each cycle:
  - If mplier[0], acc<=alu_result; otherwise acc holds.
  - mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
  - When cnt==REG_LENGTH-1, go to WB.
- WB: when slot_free, out_data<=acc, out_wr/out_addr<=latched values, out_valid<=1, go to IDLE. Otherwise hold.
- Slot drain: out_valid && out_ready with no load in the same cycle sets out_valid<=0.
- Slot load and drain in the same cycle are legal; the new result replaces the old one.
- Arithmetic: product is the low REG_LENGTH bits of in_a*in_b, modulo 2^REG_LENGTH, identical for signed and unsigned operands. acc additions wrap. cnt is ceil(log2(REG_LENGTH)) bits.
- in_valid while in_ready==0 is ignored; the issuer must hold the request.
- The block keeps no queue: at most one op in flight plus one result in the slot.

## Timing
- Reset (async on rst_n low):
  - state=IDLE, out_valid=0, out_data=0, out_wr=0, out_addr=0.
  - acc, mcand, mplier, cnt = 0.
  - busy=0, in_ready=0 while rst_n low.
- Reset mid-MUL or mid-WB discards the op; no result is produced.
- Single-cycle op accepted at edge E: out_valid is high after E. Throughput is 1 op/cycle while out_ready=1.
- MUL accepted at edge E:
  - Iterations run on edges E+1..E+REG_LENGTH.
  - WB is entered after E+REG_LENGTH.
  - Earliest out_valid is after E+REG_LENGTH+1 (E+33 at default width).
  - in_ready is low from after E until WB completes.
- Backpressure: out_data, out_wr and out_addr are stable while out_valid && !out_ready.
- WB stalls indefinitely while the slot is full and not drained.

## Test plan
- ADD, in_a=5, in_b=7, in_wr=1, in_addr=3, out_ready=1:
  - out_valid is high one cycle after accept.
  - out_data=12, out_wr=1, out_addr=3.
- MUL 3*5:
  - busy=1 and in_ready=0 for 33 cycles.
  - out_data=15 after edge E+33.
  - alu_op=CMD_ADD_CODE throughout MUL.
- MUL width and wrap:
  - 0xFFFFFFFF*0xFFFFFFFF -> out_data 0x00000001.
  - 0x00010000*0x00010000 -> out_data 0.
  - 0*0x1234 -> out_data 0.
- Backpressure:
  - out_ready=0, issue ADD 1+1, then present ADD 2+2: in_ready=0 and out_data stays 2.
  - Raise out_ready: next accept yields 4.
  - MUL finishing with out_ready=0 holds in WB until released.
- Reset mid-MUL: pulse rst_n low at iteration 10.
  - Immediately: out_valid=0, busy=0, out_data=0.
  - After release, ADD 9+1 -> out_data 10.
- Back-to-back: 8 consecutive ADDs with out_ready=1 produce 8 results on 8 consecutive cycles, in order, with no gaps.

Source files
------------

// File: rtl/ex_seq_ctrl_if.sv
// Bundle of the issue, ALU and result-slot signals of the EX-stage sequencer.
// The slave modport is the sequencer; the master modport is its surroundings
// (ID issue side, combinational ALU and MEM/WB consumer).
interface ex_seq_ctrl_if #(
    parameter int REG_LENGTH   = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int OP_LENGTH    = 6
);
    // issue side
    logic                    in_valid;
    logic                    in_ready;
    logic [OP_LENGTH-1:0]    in_op;
    logic [REG_LENGTH-1:0]   in_a;
    logic [REG_LENGTH-1:0]   in_b;
    logic                    in_wr;
    logic [REG_ADDR_LEN-1:0] in_addr;
    // combinational ALU
    logic [OP_LENGTH-1:0]    alu_op;
    logic [REG_LENGTH-1:0]   alu_a;
    logic [REG_LENGTH-1:0]   alu_b;
    logic [REG_LENGTH-1:0]   alu_result;
    // result slot
    logic                    out_valid;
    logic                    out_ready;
    logic [REG_LENGTH-1:0]   out_data;
    logic                    out_wr;
    logic [REG_ADDR_LEN-1:0] out_addr;
    // status
    logic                    busy;

    modport master (
        output in_valid, in_op, in_a, in_b, in_wr, in_addr, alu_result, out_ready,
        input  in_ready, alu_op, alu_a, alu_b, out_valid, out_data, out_wr, out_addr, busy
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_wr, in_addr, alu_result, out_ready,
        output in_ready, alu_op, alu_a, alu_b, out_valid, out_data, out_wr, out_addr, busy
    );
endinterface

// File: rtl/ex_seq_ctrl.sv
// EX-stage sequencer: single-cycle ALU ops go straight into a registered
// result slot; multiplies run as a shift-and-add loop over the ALU add path.
module ex_seq_ctrl #(
    parameter int                   REG_LENGTH   = 32,
    parameter int                   REG_ADDR_LEN = 5,
    parameter int                   OP_LENGTH    = 6,
    parameter logic [OP_LENGTH-1:0] CMD_ADD_CODE = 6'h01,
    parameter logic [OP_LENGTH-1:0] CMD_MUL_CODE = 6'h20
) (
    input  logic          clk,
    input  logic          rst_n,
    ex_seq_ctrl_if.slave  bus
);

    localparam int CNT_W = (REG_LENGTH > 1) ? $clog2(REG_LENGTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REG_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t                  r_state, w_state_next;
    logic [REG_LENGTH-1:0]   r_acc, w_acc_next;
    logic [REG_LENGTH-1:0]   r_mcand, w_mcand_next;
    logic [REG_LENGTH-1:0]   r_mplier, w_mplier_next;
    logic [CNT_W-1:0]        r_cnt, w_cnt_next;
    logic                    r_wr, w_wr_next;
    logic [REG_ADDR_LEN-1:0] r_addr, w_addr_next;
    logic                    r_out_valid, w_out_valid_next;
    logic [REG_LENGTH-1:0]   r_out_data, w_out_data_next;
    logic                    r_out_wr, w_out_wr_next;
    logic [REG_ADDR_LEN-1:0] r_out_addr, w_out_addr_next;

    logic w_slot_free;
    logic w_accept;
    logic w_is_mul;

    assign w_slot_free  = !r_out_valid || bus.out_ready;
    assign bus.in_ready = rst_n && (r_state == IDLE) && w_slot_free;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_is_mul     = (bus.in_op == CMD_MUL_CODE);

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_wr    = r_out_wr;
    assign bus.out_addr  = r_out_addr;
    assign bus.busy      = (r_state != IDLE);

    // ALU operand mux: issue operands in IDLE, accumulator + shifted multiplicand otherwise.
    // A multiply op code on the issue bus is shown to the ALU as an add, so the
    // ALU never sees the multiply code; its result is ignored on that cycle anyway.
    always_comb begin
        bus.alu_op = CMD_ADD_CODE;
        bus.alu_a  = r_acc;
        bus.alu_b  = r_mcand;
        if (r_state == IDLE) begin
            bus.alu_op = w_is_mul ? CMD_ADD_CODE : bus.in_op;
            bus.alu_a  = bus.in_a;
            bus.alu_b  = bus.in_b;
        end
    end

    // Next-state and datapath update; a slot load in any state overrides the drain.
    always_comb begin
        w_state_next     = r_state;
        w_acc_next       = r_acc;
        w_mcand_next     = r_mcand;
        w_mplier_next    = r_mplier;
        w_cnt_next       = r_cnt;
        w_wr_next        = r_wr;
        w_addr_next      = r_addr;
        w_out_valid_next = r_out_valid && !bus.out_ready;
        w_out_data_next  = r_out_data;
        w_out_wr_next    = r_out_wr;
        w_out_addr_next  = r_out_addr;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_mul) begin
                        w_acc_next    = '0;
                        w_mcand_next  = bus.in_a;
                        w_mplier_next = bus.in_b;
                        w_cnt_next    = '0;
                        w_wr_next     = bus.in_wr;
                        w_addr_next   = bus.in_addr;
                        w_state_next  = MUL;
                    end else begin
                        // any non-multiply code, known or not, captures the ALU output
                        w_out_data_next  = bus.alu_result;
                        w_out_wr_next    = bus.in_wr;
                        w_out_addr_next  = bus.in_addr;
                        w_out_valid_next = 1'b1;
                    end
                end
            end
            MUL: begin
                if (r_mplier[0]) begin
                    w_acc_next = bus.alu_result;
                end
                w_mcand_next  = r_mcand << 1;
                w_mplier_next = r_mplier >> 1;
                w_cnt_next    = r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_next = WB;
                end
            end
            WB: begin
                if (w_slot_free) begin
                    w_out_data_next  = r_acc;
                    w_out_wr_next    = r_wr;
                    w_out_addr_next  = r_addr;
                    w_out_valid_next = 1'b1;
                    w_state_next     = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_wr    <= 1'b0;
            r_out_addr  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_acc       <= w_acc_next;
            r_mcand     <= w_mcand_next;
            r_mplier    <= w_mplier_next;
            r_cnt       <= w_cnt_next;
            r_wr        <= w_wr_next;
            r_addr      <= w_addr_next;
            r_out_valid <= w_out_valid_next;
            r_out_data  <= w_out_data_next;
            r_out_wr    <= w_out_wr_next;
            r_out_addr  <= w_out_addr_next;
        end
    end

endmodule

// File: tb/tb_ex_seq_ctrl.sv
// Directed bench for ex_seq_ctrl with a small behavioural ALU on the bus.
module tb_ex_seq_ctrl;

    localparam logic [5:0] ADD = 6'h01;
    localparam logic [5:0] SUB = 6'h02;
    localparam logic [5:0] MULC = 6'h20;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    ex_seq_ctrl_if bus ();

    ex_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // behavioural EX ALU: add, subtract, anything else xor
    assign bus.alu_result = (bus.alu_op == ADD) ? bus.alu_a + bus.alu_b :
                            (bus.alu_op == SUB) ? bus.alu_a - bus.alu_b :
                                                  bus.alu_a ^ bus.alu_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic wr, input logic [4:0] addr);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_wr    = wr;
        bus.in_addr  = addr;
    endtask

    // issue a multiply with out_ready=1 and check latency and product
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        int n;
        drive(MULC, a, b, 1'b1, 5'd7);
        #1;
        chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, n, 33);
        chk(tag, bus.out_data, exp);
        $display("MUL %h * %h -> %h after %0d cycles", a, b, bus.out_data, n);
        step();
    endtask

    initial begin
        int bad;
        int vcnt;
        errors = 0;
        checks = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_op     = ADD;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_wr     = 1'b0;
        bus.in_addr   = '0;
        bus.out_ready = 1'b1;

        // reset state
        #3;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        $display("reset: out_valid=%0b busy=%0b in_ready=%0b", bus.out_valid, bus.busy, bus.in_ready);
        bus.in_valid = 1'b0;
        #19;
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_valid", 32'(bus.out_valid), 32'd0);

        // single ADD
        drive(ADD, 32'd5, 32'd7, 1'b1, 5'd3);
        #1;
        chk("add_rdy", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("add_valid", 32'(bus.out_valid), 32'd1);
        chk("add_data", bus.out_data, 32'd12);
        chk("add_wr", 32'(bus.out_wr), 32'd1);
        chk("add_addr", 32'(bus.out_addr), 32'd3);
        $display("ADD 5+7 -> %0d wr=%0b addr=%0d", bus.out_data, bus.out_wr, bus.out_addr);
        step();
        chk("add_drain", 32'(bus.out_valid), 32'd0);

        // SUB through the ALU path
        drive(SUB, 32'd10, 32'd3, 1'b0, 5'd9);
        step();
        bus.in_valid = 1'b0;
        chk("sub_data", bus.out_data, 32'd7);
        chk("sub_addr", 32'(bus.out_addr), 32'd9);
        $display("SUB 10-3 -> %0d", bus.out_data);
        step();

        // MUL 3*5 with cycle-by-cycle busy/ready/alu_op checks
        drive(MULC, 32'd3, 32'd5, 1'b1, 5'd12);
        step();
        bus.in_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 33; i++) begin
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.alu_op !== ADD) bad++;
            step();
        end
        chk("mul_busy_cycles_bad", bad, 0);
        chk("mul_valid", 32'(bus.out_valid), 32'd1);
        chk("mul_data", bus.out_data, 32'd15);
        chk("mul_addr", 32'(bus.out_addr), 32'd12);
        chk("mul_busy_done", 32'(bus.busy), 32'd0);
        $display("MUL 3*5 -> %0d at E+33", bus.out_data);
        step();

        // width and wrap
        run_mul("mul_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_mul("mul_wrap", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
        run_mul("mul_zero", 32'h0000_0000, 32'h0000_1234, 32'h0000_0000);
        run_mul("mul_neg", 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA);
        run_mul("mul_mix", 32'h0000_1234, 32'h0000_5678, 32'h0626_0060);

        // backpressure on single-cycle ops
        bus.out_ready = 1'b0;
        drive(ADD, 32'd1, 32'd1, 1'b1, 5'd1);
        #1;
        chk("bp_rdy1", 32'(bus.in_ready), 32'd1);
        step();
        chk("bp_data1", bus.out_data, 32'd2);
        drive(ADD, 32'd2, 32'd2, 1'b1, 5'd2);
        #1;
        chk("bp_rdy_blocked", 32'(bus.in_ready), 32'd0);
        step();
        chk("bp_hold_data", bus.out_data, 32'd2);
        chk("bp_hold_addr", 32'(bus.out_addr), 32'd1);
        chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        step();
        chk("bp_hold_data2", bus.out_data, 32'd2);
        $display("backpressure: held out_data=%0d", bus.out_data);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_rdy_release", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("bp_data2", bus.out_data, 32'd4);
        chk("bp_addr2", 32'(bus.out_addr), 32'd2);
        $display("after release: out_data=%0d", bus.out_data);
        step();

        // MUL finishing under out_ready=0
        drive(MULC, 32'd6, 32'd7, 1'b1, 5'd5);
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (33) step();
        chk("mbp_valid", 32'(bus.out_valid), 32'd1);
        chk("mbp_data", bus.out_data, 32'd42);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd42 || bus.in_ready !== 1'b0) bad++;
        end
        chk("mbp_hold_bad", bad, 0);
        bus.out_ready = 1'b1;
        step();
        chk("mbp_drained", 32'(bus.out_valid), 32'd0);
        $display("MUL 6*7 under backpressure -> 42 held, drained");

        // reset in the middle of a multiply
        drive(MULC, 32'd3, 32'd5, 1'b1, 5'd4);
        step();
        bus.in_valid = 1'b0;
        repeat (10) step();
        chk("rmid_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rmid_valid", 32'(bus.out_valid), 32'd0);
        chk("rmid_busy", 32'(bus.busy), 32'd0);
        chk("rmid_data", bus.out_data, 32'd0);
        chk("rmid_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        rst_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 36; i++) begin
            step();
            if (bus.out_valid === 1'b1) vcnt++;
        end
        chk("rmid_no_result", vcnt, 0);
        drive(ADD, 32'd9, 32'd1, 1'b1, 5'd6);
        step();
        bus.in_valid = 1'b0;
        chk("rmid_add_data", bus.out_data, 32'd10);
        $display("reset mid-MUL, then ADD 9+1 -> %0d", bus.out_data);
        step();

        // back-to-back ADDs
        for (int i = 0; i < 8; i++) begin
            drive(ADD, 32'(i * 3), 32'(100 + i), 1'b1, 5'(i));
            #1;
            chk($sformatf("b2b_rdy%0d", i), 32'(bus.in_ready), 32'd1);
            step();
            chk($sformatf("b2b_valid%0d", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("b2b_data%0d", i), bus.out_data, 32'(100 + 4 * i));
            chk($sformatf("b2b_addr%0d", i), 32'(bus.out_addr), 32'(i));
            $display("B2B %0d: out_data=%0d addr=%0d", i, bus.out_data, bus.out_addr);
        end
        bus.in_valid = 1'b0;
        step();
        chk("b2b_drain", 32'(bus.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
